// File: rtl/tpc_dispatch_pkg.sv
// tpc_dispatch_pkg: shared state type and default sizes for the TPC job dispatcher
package tpc_dispatch_pkg;
    typedef enum logic [1:0] { S_IDLE, S_RUN, S_DRAIN, S_HALT } state_t;
    localparam int DEF_NUM_TPCS = 4;
    localparam int DEF_PC_WIDTH = 20;
    localparam int DEF_QUEUE_DEPTH = 8;
    localparam int JOBS_DONE_W = 16;
    localparam int JOBS_ERR_W = 8;
endpackage

// File: rtl/job_fifo.sv
// job_fifo: synchronous start-PC FIFO with flush and occupancy count
module job_fifo
    import tpc_dispatch_pkg::*;
#(
    parameter int WIDTH = DEF_PC_WIDTH,
    parameter int DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/tpc_job_dispatcher.sv
// tpc_job_dispatcher: queues start PCs and launches them round-robin on idle TPCs.
// Define TPC_DISPATCH_ERR_HALT_EN to halt dispatch on any counted TPC error.
module tpc_job_dispatcher
    import tpc_dispatch_pkg::*;
#(
    parameter int NUM_TPCS = DEF_NUM_TPCS,
    parameter int PC_WIDTH = DEF_PC_WIDTH,
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [PC_WIDTH-1:0]            job_pc,
    input  logic                           batch_go,
    input  logic                           batch_seal,
    input  logic                           abort,
    input  logic [NUM_TPCS-1:0]            tpc_enable,
    input  logic [NUM_TPCS-1:0]            tpc_busy,
    input  logic [NUM_TPCS-1:0]            tpc_done,
    input  logic [NUM_TPCS-1:0]            tpc_error,
    output logic [NUM_TPCS-1:0]            tpc_start,
    output logic [NUM_TPCS*PC_WIDTH-1:0]   tpc_start_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic [JOBS_DONE_W-1:0]         jobs_done,
    output logic [JOBS_ERR_W-1:0]          jobs_err,
    output logic                           halted,
    output logic                           irq
);
    localparam int IW = $clog2(NUM_TPCS);
    localparam int CW = $clog2(NUM_TPCS + 1);
    localparam int QW = $clog2(QUEUE_DEPTH) + 1;
    state_t state;
    logic [NUM_TPCS-1:0] owned, free, rot, sel, fin, err_hit, owned_nx;
    logic [IW-1:0] rr_ptr, off, pick;
    logic [IW:0] sum;
    logic [CW-1:0] n_fin, n_err;
    logic [JOBS_ERR_W:0] err_sum;
    logic [PC_WIDTH-1:0] head;
    logic active, dispatch, push, drained, halt_hit;
    assign active = state == S_RUN || state == S_DRAIN;
    assign job_ready = (state == S_IDLE || state == S_RUN) && queue_count < QW'(QUEUE_DEPTH);
    assign push = job_valid && job_ready;
    assign free = tpc_enable & ~owned & ~tpc_busy;
    assign dispatch = active && !abort && queue_count != '0 && |free;
    // Rotate so bit 0 is rr_ptr, then take the lowest free offset
    assign rot = NUM_TPCS'({free, free} >> rr_ptr);
    always_comb begin
        off = '0;
        for (int k = NUM_TPCS - 1; k >= 0; k--)
            if (rot[k]) off = IW'(k);
    end
    assign sum = {1'b0, rr_ptr} + {1'b0, off};
    assign pick = sum >= (IW+1)'(NUM_TPCS) ? IW'(sum - (IW+1)'(NUM_TPCS)) : sum[IW-1:0];
    assign sel = dispatch ? NUM_TPCS'(1) << pick : '0;
    assign fin = (tpc_done | tpc_error) & owned;
    assign err_hit = tpc_error & owned;
    assign owned_nx = (owned & ~fin) | sel;
    assign drained = state == S_DRAIN && queue_count == '0 && owned_nx == '0;
    always_comb begin
        n_fin = '0;
        n_err = '0;
        for (int i = 0; i < NUM_TPCS; i++) begin
            n_fin = n_fin + CW'(fin[i]);
            n_err = n_err + CW'(err_hit[i]);
        end
    end
    assign err_sum = {1'b0, jobs_err} + (JOBS_ERR_W+1)'(n_err);
`ifdef TPC_DISPATCH_ERR_HALT_EN
    assign halt_hit = active && |err_hit;
    assign halted = state == S_HALT;
`else
    assign halt_hit = 1'b0;
    assign halted = 1'b0;
`endif
    job_fifo #(.WIDTH(PC_WIDTH), .DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(dispatch), .flush(abort),
        .din(job_pc), .dout(head), .count(queue_count)
    );
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state <= S_IDLE;
            owned <= '0;
            rr_ptr <= '0;
            jobs_done <= '0;
            jobs_err <= '0;
            tpc_start <= '0;
            irq <= 1'b0;
        end else begin
            owned <= owned_nx;
            tpc_start <= sel;
            jobs_done <= jobs_done + JOBS_DONE_W'(n_fin);
            jobs_err <= err_sum[JOBS_ERR_W] ? '1 : err_sum[JOBS_ERR_W-1:0];
            irq <= drained && !halt_hit;
            if (dispatch) rr_ptr <= pick == IW'(NUM_TPCS - 1) ? '0 : pick + 1'b1;
            if (halt_hit) state <= S_HALT;
            else if (drained) state <= S_IDLE;
            else if (state == S_IDLE && batch_go) state <= S_RUN;
            else if (state == S_RUN && batch_seal) state <= S_DRAIN;
        end
    end
    // PC slices persist until the next launch to the same TPC
    always_ff @(posedge clk) begin
        if (rst) tpc_start_pc <= '0;
        else if (dispatch) tpc_start_pc[pick*PC_WIDTH +: PC_WIDTH] <= head;
    end
endmodule

// File: tb/tb_tpc_job_dispatcher.sv
// tb_tpc_job_dispatcher: directed self-checking bench for tpc_job_dispatcher
module tb_tpc_job_dispatcher;
    localparam int N = 4;
    localparam int PW = 20;
    localparam int QD = 8;
    localparam logic [3:0] DTAB [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0100};
    localparam logic [3:0] STAB [9] = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic job_valid = 1'b0;
    logic job_ready;
    logic [PW-1:0] job_pc = '0;
    logic batch_go = 1'b0;
    logic batch_seal = 1'b0;
    logic abort = 1'b0;
    logic [N-1:0] tpc_enable = '0;
    logic [N-1:0] tpc_busy = '0;
    logic [N-1:0] tpc_done = '0;
    logic [N-1:0] tpc_error = '0;
    logic [N-1:0] tpc_start;
    logic [N*PW-1:0] tpc_start_pc;
    logic [3:0] queue_count;
    logic [15:0] jobs_done;
    logic [7:0] jobs_err;
    logic halted;
    logic irq;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tpc_job_dispatcher #(.NUM_TPCS(N), .PC_WIDTH(PW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_pc(job_pc),
        .batch_go(batch_go), .batch_seal(batch_seal), .abort(abort),
        .tpc_enable(tpc_enable), .tpc_busy(tpc_busy), .tpc_done(tpc_done), .tpc_error(tpc_error),
        .tpc_start(tpc_start), .tpc_start_pc(tpc_start_pc), .queue_count(queue_count),
        .jobs_done(jobs_done), .jobs_err(jobs_err), .halted(halted), .irq(irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        job_valid = 0; job_pc = '0; batch_go = 0; batch_seal = 0; abort = 0;
        tpc_enable = '0; tpc_busy = '0; tpc_done = '0; tpc_error = '0;
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (tpc_start !== 4'b0000) begin n_bad++; $display("FAIL reset_start: got %b want 0000", tpc_start); end
        n_cmp++; if (tpc_start_pc !== '0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", tpc_start_pc); end
        n_cmp++; if (queue_count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        n_cmp++; if (jobs_done !== 16'd0) begin n_bad++; $display("FAIL reset_done: got %0d want 0", jobs_done); end
        n_cmp++; if (jobs_err !== 8'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", jobs_err); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", job_ready); end
    endtask

    task automatic test_dispatch_all();
        do_reset();
        tpc_enable = 4'b1111;
        job_valid = 1;
        for (int i = 0; i < 4; i++) begin
            job_pc = PW'(20'h100 + i);
            step();
        end
        job_valid = 0;
        n_cmp++; if (queue_count !== 4'd4 || tpc_start !== 4'b0000) begin n_bad++; $display("FAIL idle_hold: got count %0d start %b want 4 0000", queue_count, tpc_start); end
        batch_go = 1;
        step();
        batch_go = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (tpc_start !== 4'(1 << i)) begin n_bad++; $display("FAIL rr_start%0d: got %b want %b", i, tpc_start, 4'(1 << i)); end
            n_cmp++; if (tpc_start_pc[i*PW +: PW] !== PW'(20'h100 + i)) begin n_bad++; $display("FAIL rr_pc%0d: got %h want %h", i, tpc_start_pc[i*PW +: PW], 20'h100 + i); end
        end
        step();
        n_cmp++; if (tpc_start !== 4'b0000 || queue_count !== 4'd0) begin n_bad++; $display("FAIL rr_empty: got start %b count %0d want 0000 0", tpc_start, queue_count); end
        tpc_done = 4'b1111;
        step();
        tpc_done = '0;
        n_cmp++; if (jobs_done !== 16'd4) begin n_bad++; $display("FAIL multi_done: got %0d want 4", jobs_done); end
    endtask

    task automatic test_enable_mask();
        int k;
        do_reset();
        tpc_enable = 4'b0101;
        job_valid = 1;
        for (int i = 0; i < 4; i++) begin
            job_pc = PW'(20'h200 + i);
            step();
        end
        job_valid = 0;
        batch_go = 1;
        step();
        batch_go = 0;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            tpc_done = DTAB[c];
            step();
            n_cmp++; if (tpc_start !== STAB[c]) begin n_bad++; $display("FAIL mask_start_c%0d: got %b want %b", c + 1, tpc_start, STAB[c]); end
            if (STAB[c] != 4'b0000) begin
                n_cmp++;
                if (tpc_start_pc[(STAB[c] == 4'b0001 ? 0 : 2)*PW +: PW] !== PW'(20'h200 + k)) begin
                    n_bad++; $display("FAIL mask_pc_c%0d: got %h want %h", c + 1, tpc_start_pc[(STAB[c] == 4'b0001 ? 0 : 2)*PW +: PW], 20'h200 + k);
                end
                k++;
            end
        end
        tpc_done = '0;
        n_cmp++; if (jobs_done !== 16'd4) begin n_bad++; $display("FAIL mask_done: got %0d want 4", jobs_done); end
    endtask

    task automatic test_full();
        do_reset();
        tpc_enable = 4'b1111;
        job_valid = 1;
        for (int i = 0; i < 8; i++) begin
            job_pc = PW'(20'h300 + i);
            n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready%0d: got %b want 1", i, job_ready); end
            step();
        end
        n_cmp++; if (queue_count !== 4'd8 || job_ready !== 1'b0) begin n_bad++; $display("FAIL full_state: got count %0d ready %b want 8 0", queue_count, job_ready); end
        job_pc = 20'h308;
        step();
        n_cmp++; if (queue_count !== 4'd8) begin n_bad++; $display("FAIL full_stall: got %0d want 8", queue_count); end
        batch_go = 1;
        step();
        batch_go = 0;
        n_cmp++; if (queue_count !== 4'd8) begin n_bad++; $display("FAIL full_go: got %0d want 8", queue_count); end
        step();
        n_cmp++; if (queue_count !== 4'd7 || tpc_start !== 4'b0001 || job_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop: got count %0d start %b ready %b want 7 0001 1", queue_count, tpc_start, job_ready); end
        n_cmp++; if (tpc_start_pc[0 +: PW] !== 20'h300) begin n_bad++; $display("FAIL full_pc0: got %h want 00300", tpc_start_pc[0 +: PW]); end
        step();
        job_valid = 0;
        n_cmp++; if (queue_count !== 4'd7 || tpc_start !== 4'b0010) begin n_bad++; $display("FAIL push_pop: got count %0d start %b want 7 0010", queue_count, tpc_start); end
        n_cmp++; if (tpc_start_pc[PW +: PW] !== 20'h301) begin n_bad++; $display("FAIL full_pc1: got %h want 00301", tpc_start_pc[PW +: PW]); end
    endtask

    task automatic test_seal_irq();
        do_reset();
        tpc_enable = 4'b1111;
        tpc_busy = 4'b1111;
        job_valid = 1;
        for (int i = 0; i < 2; i++) begin
            job_pc = PW'(20'h400 + i);
            step();
        end
        job_valid = 0;
        batch_go = 1;
        step();
        batch_go = 0;
        batch_seal = 1;
        step();
        batch_seal = 0;
        n_cmp++; if (job_ready !== 1'b0 || queue_count !== 4'd2) begin n_bad++; $display("FAIL drain_ready: got ready %b count %0d want 0 2", job_ready, queue_count); end
        tpc_busy = '0;
        step();
        n_cmp++; if (tpc_start !== 4'b0001 || irq !== 1'b0) begin n_bad++; $display("FAIL drain_d0: got start %b irq %b want 0001 0", tpc_start, irq); end
        step();
        n_cmp++; if (tpc_start !== 4'b0010 || queue_count !== 4'd0 || irq !== 1'b0) begin n_bad++; $display("FAIL drain_d1: got start %b count %0d irq %b want 0010 0 0", tpc_start, queue_count, irq); end
        tpc_done = 4'b0011;
        step();
        tpc_done = '0;
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_pulse: got %b want 1", irq); end
        n_cmp++; if (jobs_done !== 16'd2 || job_ready !== 1'b1) begin n_bad++; $display("FAIL irq_idle: got done %0d ready %b want 2 1", jobs_done, job_ready); end
        step();
        n_cmp++; if (irq !== 1'b0 || tpc_start !== 4'b0000) begin n_bad++; $display("FAIL irq_single: got irq %b start %b want 0 0000", irq, tpc_start); end
    endtask

    task automatic test_error();
        do_reset();
        tpc_enable = 4'b0011;
        job_valid = 1;
        for (int i = 0; i < 4; i++) begin
            job_pc = PW'(20'h500 + i);
            step();
        end
        job_valid = 0;
        batch_go = 1;
        step();
        batch_go = 0;
        step();
        step();
        n_cmp++; if (tpc_start !== 4'b0010) begin n_bad++; $display("FAIL err_start1: got %b want 0010", tpc_start); end
        step();
        tpc_error = 4'b0010;
        tpc_done = 4'b1000;
        step();
        tpc_error = '0;
        tpc_done = '0;
        n_cmp++; if (jobs_err !== 8'd1 || jobs_done !== 16'd1) begin n_bad++; $display("FAIL err_count: got err %0d done %0d want 1 1", jobs_err, jobs_done); end
        step();
`ifdef TPC_DISPATCH_ERR_HALT_EN
        n_cmp++; if (halted !== 1'b1 || tpc_start !== 4'b0000 || job_ready !== 1'b0) begin n_bad++; $display("FAIL err_halt: got halted %b start %b ready %b want 1 0000 0", halted, tpc_start, job_ready); end
`else
        n_cmp++; if (halted !== 1'b0 || tpc_start !== 4'b0010 || queue_count !== 4'd1) begin n_bad++; $display("FAIL err_cont: got halted %b start %b count %0d want 0 0010 1", halted, tpc_start, queue_count); end
        n_cmp++; if (tpc_start_pc[PW +: PW] !== 20'h502) begin n_bad++; $display("FAIL err_pc: got %h want 00502", tpc_start_pc[PW +: PW]); end
`endif
    endtask

    task automatic test_abort();
        do_reset();
        tpc_enable = 4'b1111;
        tpc_busy = 4'b1110;
        job_valid = 1;
        for (int i = 0; i < 4; i++) begin
            job_pc = PW'(20'h600 + i);
            step();
        end
        job_valid = 0;
        batch_go = 1;
        step();
        batch_go = 0;
        step();
        tpc_busy = 4'b1111;
        tpc_done = 4'b0001;
        step();
        tpc_done = '0;
        batch_seal = 1;
        step();
        batch_seal = 0;
        n_cmp++; if (jobs_done !== 16'd1 || queue_count !== 4'd3 || job_ready !== 1'b0) begin n_bad++; $display("FAIL abort_pre: got done %0d count %0d ready %b want 1 3 0", jobs_done, queue_count, job_ready); end
        abort = 1;
        step();
        abort = 0;
        n_cmp++; if (queue_count !== 4'd0 || jobs_done !== 16'd0 || irq !== 1'b0) begin n_bad++; $display("FAIL abort_clear: got count %0d done %0d irq %b want 0 0 0", queue_count, jobs_done, irq); end
        n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", job_ready); end
        step();
        n_cmp++; if (irq !== 1'b0 || tpc_start !== 4'b0000) begin n_bad++; $display("FAIL abort_quiet: got irq %b start %b want 0 0000", irq, tpc_start); end
    endtask

    initial begin
        test_reset();
        test_dispatch_all();
        test_enable_mask();
        test_full();
        test_seal_irq();
        test_error();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tpc_job_dispatcher.md
# tpc_job_dispatcher

Queues TPC program launches (start PCs) and dispatches them round-robin to idle, enabled TPCs, one start per cycle. Tracks per-TPC ownership until done/error, counts completions, and raises a one-cycle completion interrupt when a sealed batch fully drains. Sits beside the global command processor, driving the same `tpc_start`/`tpc_start_pc` bus and consuming `tpc_busy`/`tpc_done`/`tpc_error`.

## Interface
- `NUM_TPCS`, 4, number of TPCs (2..16)
- `PC_WIDTH`, 20, start-PC width
- `QUEUE_DEPTH`, 8, job FIFO entries (power of two, ≥2)
- `clk` in 1, single clock
- `rst` in 1, synchronous, active-high reset
- `job_valid` in 1, job offered
- `job_ready` out 1, job accepted when `job_valid && job_ready`
- `job_pc` in PC_WIDTH, start PC of offered job
- `batch_go` in 1, pulse: IDLE→RUN
- `batch_seal` in 1, pulse: RUN→DRAIN (no further jobs this batch)
- `abort` in 1, pulse: flush queue and ownership, return to IDLE
- `tpc_enable` in NUM_TPCS, eligibility mask
- `tpc_busy`, `tpc_done`, `tpc_error` in NUM_TPCS each, TPC status; done/error are 1-cycle pulses
- `tpc_start` out NUM_TPCS, 1-cycle launch pulse, at most one bit set
- `tpc_start_pc` out NUM_TPCS*PC_WIDTH, per-TPC PC, slice i = bits [i*PC_WIDTH +: PC_WIDTH]
- `queue_count` out $clog2(QUEUE_DEPTH)+1, queued jobs
- `jobs_done` out 16, completions since reset/abort, wraps
- `jobs_err` out 8, errored completions, saturates at 255
- `halted` out 1, in HALT state
- `irq` out 1, 1-cycle batch-complete pulse

## Operation
- States: IDLE, RUN, DRAIN, HALT. Reset → IDLE.
- IDLE: accepts jobs, no dispatch; `batch_go` → RUN.
- RUN: accepts jobs and dispatches; `batch_seal` → DRAIN.
- DRAIN: `job_ready`=0; dispatches remaining; when queue empty and owned mask zero → IDLE with `irq`=1 that cycle.
- HALT: see Configuration; only `abort` or `rst` leaves.
- `job_ready` = state∈{IDLE,RUN} && `queue_count` < QUEUE_DEPTH (from registered count; no push-through-when-full).
- Free TPC i = `tpc_enable[i]` && !owned[i] && !`tpc_busy[i]`.
- Dispatch (RUN/DRAIN, queue non-empty, any free): pick first free index searching from `rr_ptr` upward mod NUM_TPCS; pop head; pulse `tpc_start[i]`; load slice i with PC (held until next start to i); set owned[i]; `rr_ptr` ← i+1 mod NUM_TPCS.
- `tpc_done[i]` or `tpc_error[i]` with owned[i]: clear owned[i], `jobs_done`+1; error also `jobs_err`+1. Pulses on non-owned TPCs ignored.
- `tpc_enable[i]` dropped while owned: ownership kept until done/error.
- `abort`: clear FIFO, owned, `rr_ptr`, counters; → IDLE; no `irq`; priority over all other inputs except `rst`.
- `batch_go` outside IDLE, `batch_seal` outside RUN: ignored.

## Timing
- Reset values: `tpc_start`=0, `tpc_start_pc`=0, `queue_count`=0, `jobs_done`=0, `jobs_err`=0, `halted`=0, `irq`=0; `job_ready`=1 first cycle after reset.
- Push at cycle N into empty queue in RUN with a free TPC → `tpc_start` pulse at N+1.
- `tpc_start` and its PC slice are registered, valid same cycle.
- Done pulse at N → owned clear at N+1 → TPC redispatchable at N+1 (start pulse at N+2 at earliest).
- Simultaneous push and pop: count unchanged.
- Simultaneous done on multiple TPCs: all counted same cycle.
- `irq` asserted in the cycle state returns to IDLE.

## Configuration
- `TPC_DISPATCH_ERR_HALT_EN` defined: any counted `tpc_error` moves RUN/DRAIN → HALT next cycle; dispatch stops, `job_ready`=0, `halted`=1; outstanding done/error still counted; no `irq`.
- Not defined: errors only increment `jobs_err`; dispatch continues; HALT unreachable, `halted` tied 0.

## Structure
- Package `tpc_dispatch_pkg`: state enum, default widths, `JOBS_DONE_W`=16, `JOBS_ERR_W`=8.
- Sub-module `job_fifo`: synchronous FIFO (PC_WIDTH × QUEUE_DEPTH, push/pop/flush/count). Arbiter, ownership, counters and FSM in top.

## Test plan
- Reset, push PCs 0x100..0x103, `batch_go`, all enabled → starts to TPC0..3 on consecutive cycles with matching PCs.
- Enable 4'b0101, push 4 jobs, done each on start+3 → starts alternate TPC0/TPC2 only; `jobs_done`=4.
- Push 8 jobs (queue full) → `job_ready`=0 with `queue_count`=8; 9th push stalls until first dispatch.
- `batch_seal` with 2 jobs queued, complete all → single `irq` pulse the cycle owned mask and queue reach zero; state IDLE.
- `tpc_error[1]` on owned TPC1: with macro → `halted`=1, no further starts; without → `jobs_err`=1, dispatch continues.
- `abort` mid-DRAIN with 3 queued → `queue_count`=0, `jobs_done`=0, no `irq`, `job_ready`=1 next cycle.
